// File: rtl/wm_packer_pkg.sv
// Shared types and width helpers for the watermark pixel packer.
// Optional frame checksum is enabled by WM_PACKER_CHECKSUM_EN.
package wm_packer_pkg;

  localparam int AMBA_WORD_DEF  = 16;
  localparam int DATA_DEPTH_DEF = 8;

  function automatic int ppw_f(int aw, int dd);
    return aw / dd;
  endfunction

  function automatic int keep_w_f(int ppw);
    return $clog2(ppw) + 1;
  endfunction

  typedef enum logic [1:0] {
    COLLECT,
    FLUSH,
    DRAIN,
    DONE
  } state_t;

  localparam int KEEP_W_DEF =
    keep_w_f(ppw_f(AMBA_WORD_DEF, DATA_DEPTH_DEF));

  typedef struct packed {
    logic                     last;
    logic [KEEP_W_DEF-1:0]    keep;
    logic [AMBA_WORD_DEF-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/wm_sync_fifo.sv
// Synchronous FIFO with a registered head; a push into a full FIFO
// is accepted only when a pop happens in the same cycle.
module wm_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = empty_o ? '0 : mem_q[rd_q];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/wm_pixel_packer.sv
// Packs watermarked pixels into bus words with last/keep framing.
// Define WM_PACKER_CHECKSUM_EN to add the frame_checksum output.
module wm_pixel_packer
  import wm_packer_pkg::*;
#(
  parameter int Amba_Word  = AMBA_WORD_DEF,
  parameter int Data_Depth = DATA_DEPTH_DEF,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16,
  localparam int PPW = ppw_f(Amba_Word, Data_Depth),
  localparam int KW  = keep_w_f(PPW)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  new_pixel,
  input  logic [Data_Depth-1:0] Pixel_Data,
  input  logic                  Image_Done,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [Amba_Word-1:0]  out_data,
  output logic [KW-1:0]         out_keep,
  output logic                  out_last,
  output logic                  frame_done,
  output logic [CNT_W-1:0]      pixel_count,
`ifdef WM_PACKER_CHECKSUM_EN
  output logic [15:0]           frame_checksum,
`endif
  output logic                  overflow
);

  typedef struct packed {
    logic                 last;
    logic [KW-1:0]        keep;
    logic [Amba_Word-1:0] data;
  } entry_t;

  state_t               state_q, state_d;
  logic [KW-1:0]        lane_q, lane_d;
  logic [Amba_Word-1:0] word_q, word_d;
  logic [Amba_Word-1:0] stg_q, stg_d;
  logic                 stg_v_q, stg_v_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 dempty_q, dempty_d;
  logic                 idone_q;
`ifdef WM_PACKER_CHECKSUM_EN
  logic [15:0]          sum_q, sum_d;
`endif

  entry_t push_e, head;
  logic   push, push_ok, full, empty, hs, rise, take;

  assign hs      = !empty && out_ready;
  assign push_ok = !full || hs;
  assign rise    = Image_Done && !idone_q;

  always_comb begin
    state_d  = state_q;
    lane_d   = lane_q;
    word_d   = word_q;
    stg_d    = stg_q;
    stg_v_d  = stg_v_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    dempty_d = dempty_q;
    push     = 1'b0;
    push_e   = '0;
    take     = 1'b0;
`ifdef WM_PACKER_CHECKSUM_EN
    sum_d    = sum_q;
`endif
    unique case (state_q)
      COLLECT: begin
        if (new_pixel) begin
          take = 1'b1;
          if (stg_v_q) begin
            push        = 1'b1;
            push_e.keep = KW'(PPW);
            push_e.data = stg_q;
            stg_v_d     = 1'b0;
          end
          word_d[int'(lane_q)*Data_Depth +: Data_Depth] = Pixel_Data;
          lane_d = lane_q + KW'(1);
          if (lane_d == KW'(PPW)) begin
            stg_d   = word_d;
            stg_v_d = 1'b1;
            word_d  = '0;
            lane_d  = '0;
          end
        end
        if (rise) state_d = FLUSH;
      end
      FLUSH: begin
        // A staged word must precede the partial one, costing a cycle.
        if (lane_q != '0 && stg_v_q) begin
          push        = 1'b1;
          push_e.keep = KW'(PPW);
          push_e.data = stg_q;
          stg_v_d     = 1'b0;
        end else if (lane_q != '0) begin
          push        = 1'b1;
          push_e.last = 1'b1;
          push_e.keep = lane_q;
          push_e.data = word_q;
          lane_d      = '0;
          word_d      = '0;
          dempty_d    = !push_ok;
          state_d     = DRAIN;
        end else if (stg_v_q) begin
          push        = 1'b1;
          push_e.last = 1'b1;
          push_e.keep = KW'(PPW);
          push_e.data = stg_q;
          stg_v_d     = 1'b0;
          dempty_d    = !push_ok;
          state_d     = DRAIN;
        end else begin
          dempty_d = 1'b1;
          state_d  = DRAIN;
        end
      end
      DRAIN: begin
        if (dempty_q ? empty : (hs && head.last)) state_d = DONE;
      end
      DONE: begin
        state_d = COLLECT;
        cnt_d   = '0;
`ifdef WM_PACKER_CHECKSUM_EN
        sum_d   = '0;
`endif
      end
      default: state_d = COLLECT;
    endcase
    if (take) begin
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
`ifdef WM_PACKER_CHECKSUM_EN
      sum_d = sum_q + 16'(Pixel_Data);
`endif
    end
    if (new_pixel && state_q != COLLECT) ovf_d = 1'b1;
    if (push && !push_ok) ovf_d = 1'b1;
  end

  // Edge register resets high so a level held through reset is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= COLLECT;
      lane_q   <= '0;
      word_q   <= '0;
      stg_q    <= '0;
      stg_v_q  <= 1'b0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      dempty_q <= 1'b0;
      idone_q  <= 1'b1;
`ifdef WM_PACKER_CHECKSUM_EN
      sum_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      lane_q   <= lane_d;
      word_q   <= word_d;
      stg_q    <= stg_d;
      stg_v_q  <= stg_v_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      dempty_q <= dempty_d;
      idone_q  <= Image_Done;
`ifdef WM_PACKER_CHECKSUM_EN
      sum_q    <= sum_d;
`endif
    end
  end

  wm_sync_fifo #(
    .W     ($bits(entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (push_e),
    .pop_i   (hs),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  assign out_valid   = !empty;
  assign out_data    = head.data;
  assign out_keep    = head.keep;
  assign out_last    = head.last;
  assign frame_done  = (state_q == DONE);
  assign pixel_count = cnt_q;
  assign overflow    = ovf_q;
`ifdef WM_PACKER_CHECKSUM_EN
  assign frame_checksum = sum_q;
`endif

endmodule

// File: tb/tb_wm_pixel_packer.sv
// Self-checking bench for wm_pixel_packer: directed frames plus
// random frames checked against a word-list model of the framing rules.
module tb_wm_pixel_packer;

  localparam int AW    = 16;
  localparam int DD    = 8;
  localparam int PPW   = AW / DD;
  localparam int KW    = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          new_pixel;
  logic [DD-1:0] Pixel_Data;
  logic          Image_Done;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_data;
  logic [KW-1:0] out_keep;
  logic          out_last;
  logic          frame_done;
  logic [15:0]   pixel_count;
  logic          overflow;
`ifdef WM_PACKER_CHECKSUM_EN
  logic [15:0]   frame_checksum;
`endif

  wm_pixel_packer dut (
    .clk         (clk),
    .rst         (rst),
    .new_pixel   (new_pixel),
    .Pixel_Data  (Pixel_Data),
    .Image_Done  (Image_Done),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_keep    (out_keep),
    .out_last    (out_last),
    .frame_done  (frame_done),
    .pixel_count (pixel_count),
`ifdef WM_PACKER_CHECKSUM_EN
    .frame_checksum (frame_checksum),
`endif
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int data;
    int keep;
    int last;
  } word_t;

  word_t       exp_q[$];
  word_t       mw;
  logic [7:0]  px[$];
  int          nchk = 0;
  int          nerr = 0;
  int          fd_cnt = 0;
  int          exp_cnt = 0;
  int          exp_sum = 0;
  int          exp_lasths = 0;
  bit          rmode = 0;
  logic        rfix = 1'b1;
  logic        prev_stall = 1'b0;
  logic        prev_lasths = 1'b0;
  logic [18:0] prev_word = '0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rmode ? 1'($urandom_range(0, 1)) : rfix;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall) begin
        chk("stall_valid", 32'(out_valid), 1);
        chk("stall_word", 32'({out_last, out_keep, out_data}),
            32'(prev_word));
      end
      if (out_valid && out_ready) begin
        chk("word_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          mw = exp_q.pop_front();
          chk("out_data", 32'(out_data), mw.data);
          chk("out_keep", 32'(out_keep), mw.keep);
          chk("out_last", 32'(out_last), mw.last);
        end
      end
      if (frame_done) begin
        fd_cnt++;
        chk("fd_pixel_count", 32'(pixel_count), exp_cnt);
        chk("fd_after_last_hs", 32'(prev_lasths), exp_lasths);
`ifdef WM_PACKER_CHECKSUM_EN
        chk("fd_checksum", 32'(frame_checksum), exp_sum & 'hFFFF);
`endif
      end
      prev_stall  = out_valid && !out_ready;
      prev_lasths = out_valid && out_ready && out_last;
      prev_word   = {out_last, out_keep, out_data};
    end else begin
      prev_stall  = 1'b0;
      prev_lasths = 1'b0;
    end
  end

  // Expected words come straight from the pixel list: PPW per word,
  // earliest pixel in lane 0, final word marked last.
  task automatic model_frame();
    int n;
    n = px.size();
    exp_cnt = n;
    exp_sum = 0;
    foreach (px[i]) exp_sum += int'(px[i]);
    exp_lasths = (n != 0);
    for (int i = 0; i < n; i += PPW) begin
      word_t w;
      w.data = 0;
      w.keep = (n - i < PPW) ? n - i : PPW;
      for (int j = 0; j < w.keep; j++)
        w.data |= int'(px[i+j]) << (DD * j);
      w.last = (i + PPW >= n);
      exp_q.push_back(w);
    end
  endtask

  task automatic wait_done(input int prev);
    for (int k = 0; k < 400 && fd_cnt == prev; k++) tick();
    chk("frame_done_seen", 32'(fd_cnt - prev), 1);
    chk("count_cleared", 32'(pixel_count), 0);
    repeat (3) tick();
    chk("frame_done_once", 32'(fd_cnt - prev), 1);
    chk("words_drained", 32'(exp_q.size()), 0);
  endtask

  task automatic run_frame(input bit gaps, input bit dwl);
    int n;
    int prev;
    n = px.size();
    model_frame();
    prev = fd_cnt;
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      new_pixel  = 1'b1;
      Pixel_Data = px[i];
      if (dwl && i == n - 1) Image_Done = 1'b1;
      tick();
      new_pixel = 1'b0;
    end
    if (!(dwl && n != 0)) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      Image_Done = 1'b1;
      tick();
    end
    Image_Done = 1'b0;
    wait_done(prev);
  endtask

  initial begin
    int prev;
    rst        = 1'b1;
    new_pixel  = 1'b0;
    Pixel_Data = '0;
    Image_Done = 1'b0;
    repeat (3) tick();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_keep", 32'(out_keep), 0);
    chk("rst_last", 32'(out_last), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_pixel_count", 32'(pixel_count), 0);
    chk("rst_overflow", 32'(overflow), 0);
    rst = 1'b0;
    tick();

    px = {8'h11, 8'h22, 8'h33, 8'h44};
    run_frame(0, 0);
    px = {8'hAA, 8'hBB, 8'hCC};
    run_frame(0, 0);
    px = {};
    run_frame(0, 0);
    px = {8'h44, 8'h55};
    run_frame(0, 1);

    for (int f = 0; f < 12; f++) begin
      int n;
      n = $urandom_range(1, 14);
      px = {};
      for (int i = 0; i < n; i++) px.push_back(8'($urandom));
      rmode = bit'($urandom_range(0, 1));
      run_frame(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    end
    rmode = 0;
    rfix  = 1'b1;
    tick();
    chk("no_overflow_yet", 32'(overflow), 0);

    // Stalled sink: 8 words fill the FIFO, the 9th push is dropped.
    rfix = 1'b0;
    repeat (2) tick();
    px = {};
    for (int i = 0; i < 19; i++) px.push_back(8'(i));
    model_frame();
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    mw.data = 'h12;
    mw.keep = 1;
    mw.last = 1;
    exp_q.push_back(mw);
    prev = fd_cnt;
    for (int i = 0; i < 19; i++) begin
      if (i == 18) chk("ovf_before_drop", 32'(overflow), 0);
      new_pixel  = 1'b1;
      Pixel_Data = px[i];
      tick();
    end
    new_pixel = 1'b0;
    chk("ovf_after_drop", 32'(overflow), 1);
    chk("full_head_data", 32'(out_data), 'h0100);
    rfix = 1'b1;
    for (int k = 0; k < 100 && exp_q.size() > 1; k++) tick();
    chk("overflow_drain", 32'(exp_q.size()), 1);
    Image_Done = 1'b1;
    tick();
    Image_Done = 1'b0;
    wait_done(prev);
    chk("ovf_sticky", 32'(overflow), 1);

    // Reset mid-frame with Image_Done held high through reset.
    rfix = 1'b0;
    repeat (2) tick();
    for (int i = 1; i <= 3; i++) begin
      new_pixel  = 1'b1;
      Pixel_Data = 8'(i);
      tick();
    end
    new_pixel  = 1'b0;
    Image_Done = 1'b1;
    rst        = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_count", 32'(pixel_count), 0);
    chk("mid_rst_overflow", 32'(overflow), 0);
    prev = fd_cnt;
    repeat (6) tick();
    chk("held_done_no_flush", 32'(fd_cnt - prev), 0);
    chk("held_done_no_valid", 32'(out_valid), 0);
    Image_Done = 1'b0;
    rfix = 1'b1;
    repeat (2) tick();
    px = {8'h5A, 8'hA5};
    run_frame(0, 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/wm_pixel_packer.md
Name: wm_pixel_packer

Overview:
- Downstream consumer of the watermark engine's output stream (new_pixel / Pixel_Data / Image_Done).
- Packs Data_Depth-bit modified pixels into Amba_Word-bit words and buffers them in a small FIFO.
- Presents words on a valid/ready stream with last/keep framing, and reports frame completion and overflow.

Parameters:
- Amba_Word, 16, output word width; must be an integer multiple of Data_Depth.
- Data_Depth, 8, pixel width.
- FIFO_DEPTH, 8, FIFO entries; power of 2, minimum 2.
- CNT_W, 16, width of the per-frame pixel counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- new_pixel  in  1  one-cycle strobe; Pixel_Data is valid this cycle.
- Pixel_Data  in  Data_Depth  modified pixel.
- Image_Done  in  1  level indicator; its rising edge ends the frame.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts the head word when out_valid && out_ready.
- out_data  out  Amba_Word  packed word; pixel k sits at bits [k*Data_Depth +: Data_Depth], lane 0 = earliest pixel.
- out_keep  out  $clog2(PPW)+1  number of valid pixel lanes in out_data (1..PPW).
- out_last  out  1  final word of the frame.
- frame_done  out  1  one-cycle pulse.
- pixel_count  out  CNT_W  pixels accepted in the current/last frame; saturates at all-ones.
- overflow  out  1  sticky; cleared only by rst.

Behaviour:
- Definitions:
  - PPW = Amba_Word/Data_Depth.
  - Handshake (hs) = out_valid && out_ready.
- Reset (all synchronous, applied on a clk edge with rst=1):
  - out_valid=0, out_data=0, out_keep=0, out_last=0, frame_done=0, pixel_count=0, overflow=0.
  - FIFO emptied, lane counter=0, staging register empty, state=COLLECT.
  - The Image_Done edge register resets to 1, so a level already high at reset does not start a flush.
  - rst mid-frame discards all buffered and partial data.
- Packing:
  - Each new_pixel in COLLECT writes its lane and increments the lane counter and pixel_count.
  - When the lane counter reaches PPW, the word moves to a one-word staging register with keep=PPW and the lane counter returns to 0.
- Staging:
  - A staged word is pushed to the FIFO with last=0 in the cycle the next new_pixel arrives.
  - Otherwise it is pushed with last=1 during FLUSH.
  - Staging guarantees that out_last can always be attached to the correct word.
- FIFO:
  - Registered head; out_* driven directly from the head entry {data, keep, last}.
  - Push while full is accepted only if a hs occurs in the same cycle. Otherwise the word is dropped and overflow is set.
  - Minimum latency from push to out_valid=1 is 1 cycle.
- State machine:
  - COLLECT: rising edge of Image_Done -> FLUSH. A new_pixel in the same cycle as the edge is included in the frame.
  - FLUSH, one cycle:
    - If a partial word exists (lane counter>0), push it with keep=lane counter, last=1, and unused lanes zero; any staged word is pushed first with last=0. Because this is two pushes, FLUSH takes 2 cycles in that case.
    - Else if only a staged word exists, push it with last=1.
    - Else (empty frame) push nothing.
    - Then -> DRAIN.
  - DRAIN: wait for the hs of the last=1 entry, or for the FIFO to be empty if the frame was empty -> DONE.
  - DONE, one cycle: frame_done=1; pixel_count holds its value through this cycle and clears on entry to COLLECT; -> COLLECT.
- new_pixel in FLUSH, DRAIN or DONE: pixel dropped, overflow set.
- out_data/out_keep/out_last are stable while out_valid=1 && out_ready=0.

Optional Feature:
- Macro: WM_PACKER_CHECKSUM_EN.
- When defined:
  - Adds output frame_checksum [15:0]: a modulo-2^16 sum of accepted pixels (zero-extended).
  - Updated per accepted pixel; valid and stable during frame_done; cleared on entry to COLLECT and by rst.
- When undefined: the port and adder are absent; all other behaviour is identical.

Decomposition:
- Package wm_packer_pkg:
  - PPW and keep-width localparam functions.
  - typedef enum state_t {COLLECT, FLUSH, DRAIN, DONE}.
  - Packed struct fifo_entry_t {last, keep, data}.
- One sub-module, wm_sync_fifo:
  - Parameterised on entry type/width and depth.
  - push/pop/full/empty; pop and push in the same cycle allowed when full.

Test Plan (Data_Depth=8, Amba_Word=16, FIFO_DEPTH=8, out_ready=1 unless stated):
1. Pixels 0x11,0x22,0x33,0x44 then Image_Done rise -> words 0x2211 keep=2 last=0, then 0x4433 keep=2 last=1; frame_done pulses one cycle after the second hs; pixel_count=4.
2. Pixels 0xAA,0xBB,0xCC then Image_Done -> 0xBBAA keep=2 last=0, then 0x00CC keep=1 last=1; frame_done pulses once.
3. out_ready=0, 19 pixels -> 8 FIFO entries plus 1 staged; the 19th pixel's push is dropped and overflow=1; raising out_ready drains 0x0100,0x0302,... in order.
4. Image_Done rise with no pixels -> out_valid never asserted; frame_done pulses exactly once; pixel_count=0.
5. 3 pixels then rst for 1 cycle -> next cycle out_valid=0, pixel_count=0, overflow=0; a following 2-pixel frame emits a single word with last=1.
6. new_pixel 0x55 in the same cycle as the Image_Done rise after 1 prior pixel 0x44 -> word 0x5544 keep=2 last=1; checksum (if enabled) = 0x0099.
